window_pool_comparator: RTL and testbench
=========================================

Name: window_pool_comparator

Overview:
- Streaming reduction comparator for the NPU activation path. Successor to the two-input registered comparator.
- Reduces each window of WINDOW consecutive input samples to a single max or min, with the argmax/argmin index and sample count.
- Parametrised width, window depth and signedness; ready/valid handshake on both sides; early-close (flush) of partial windows.
- Sits between the accumulator read-out and the activation write-back. Used for max/min pooling and peak detection.

Parameters:
- DATA_W, 16: sample and result width in bits.
- WINDOW, 4: samples per window; legal range 2..256.
- SIGNED, 0: 1 = two's-complement comparison, 0 = unsigned comparison.
- IDX_W, $clog2(WINDOW): width of the index field; minimum 1.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_POOL  in  1  synchronous, active-high reset.
- EN_POOL  in  1  enable; 0 stalls intake, output still drains.
- MODE  in  1  0 = max, 1 = min; sampled on first sample of each window.
- FLUSH  in  1  single-cycle pulse; closes the current partial window.
- In_Data  in  DATA_W  input sample.
- In_Valid  in  1  input sample valid.
- In_Ready  out  1  block can accept a sample this cycle.
- Out_Data  out  DATA_W  winning value of the completed window.
- Out_Index  out  IDX_W  position of the winner within its window (0 = first sample).
- Out_Count  out  IDX_W+1  number of samples reduced (WINDOW, or fewer on flush).
- Out_Valid  out  1  result valid.
- Out_Ready  in  1  downstream accepts result.

Behaviour:
- Reset: when RST_POOL is high at a clock edge, all outputs, count, best, best_idx and mode_q go to 0 and In_Ready reads 0 that cycle. Reset overrides everything, including a window in progress and a held result, which is discarded.
- In_Ready = EN_POOL & (~Out_Valid | Out_Ready). This is combinational, with no dependency on In_Valid.
- Accept = In_Valid & In_Ready.
- Internal state: count (0..WINDOW-1), best, best_idx, mode_q. State IDLE when count == 0, ACCUM when count > 0. The output register acts as a separate one-entry HOLD stage.
- Accept at count == 0: best <= In_Data, best_idx <= 0, mode_q <= MODE, count <= 1.
- Accept at 0 < count < WINDOW-1: if In_Data is strictly better than best, then best <= In_Data and best_idx <= count. count increments.
  - "Better" means greater for mode_q = 0 and smaller for mode_q = 1.
  - Signed or unsigned per SIGNED.
  - Ties keep the earlier sample, so the lowest index wins.
- Accept at count == WINDOW-1 (window completes):
  - Out_Data and Out_Index get the winner of best vs In_Data, using the same rule.
  - Out_Count <= WINDOW, Out_Valid <= 1, count <= 0.
  - Latency is 1 cycle: Out_Valid is high on the cycle after the last sample is accepted.
- Throughput is 1 sample/cycle with Out_Ready held high. The first sample of the next window is accepted in the same cycle the previous result is consumed.
- Out_Valid clears on a cycle with Out_Valid & Out_Ready and no new completion. While Out_Valid = 1 and Out_Ready = 0, all Out_* outputs hold stable.
- FLUSH, taken only when In_Ready = 1:
  - If count > 0, or an accept happens in the same cycle, the window closes with the samples so far, including any sample accepted that cycle.
  - Out_Count is the number of samples reduced. Out_Valid <= 1 next cycle, count <= 0.
- FLUSH when In_Ready = 1, count == 0 and no accept: no effect.
- FLUSH when In_Ready = 0: ignored and not remembered. Upstream re-issues it.
- FLUSH on the completing sample: behaves as a normal completion with Out_Count = WINDOW.
- MODE changes mid-window are ignored until the next window starts.
- EN_POOL = 0 mid-window: count, best and best_idx are held, and accumulation resumes when EN_POOL returns to 1.
- Arithmetic: comparisons only, no overflow. Out_Count is wide enough to hold WINDOW.

Test Plan:
- Defaults, MODE=0, Out_Ready=1, In_Data stream 3, 9, 9, 2 with In_Valid high for 4 cycles -> one cycle later Out_Data=9, Out_Index=1, Out_Count=4, Out_Valid for exactly 1 cycle.
- SIGNED=1, MODE=1, samples 16'h0005, 16'hFFFE, 16'h7FFF, 16'h8000 -> Out_Data=16'h8000, Out_Index=3. Rerun with SIGNED=0 -> Out_Data=16'h0005, Out_Index=0.
- Back-pressure: complete window 1,2,3,4 with Out_Ready=0 -> Out_Data=4 held and In_Ready=0. Hold for 5 cycles, then raise Out_Ready -> In_Ready rises and the next window 8,7,6,5 yields Out_Data=8, Out_Index=0. No sample is lost.
- Flush: samples 4, 10 then a FLUSH pulse with no sample -> Out_Data=10, Out_Index=1, Out_Count=2. A FLUSH while idle produces no output.
- Reset mid-window: after samples 50, 60, assert RST_POOL for 1 cycle, then send 1, 2, 3, 4 -> Out_Data=4, Out_Count=4. No trace of 50 or 60.
- Enable stall with a MODE change: samples 7, 3, then EN_POOL=0 and MODE switched to 1 for 3 cycles (In_Ready=0), then re-enable and send 9, 1 -> max mode is kept: Out_Data=9, Out_Index=2.

Source files
------------

// File: rtl/window_pool_comparator.sv
// Streaming window reducer: emits the max or min of each WINDOW-sample group with
// its first-occurrence index and sample count; FLUSH closes a partial window early.
module window_pool_comparator #(
    parameter int DATA_W = 16,
    parameter int WINDOW = 4,
    parameter bit SIGNED = 1'b0,
    parameter int IDX_W  = (WINDOW < 3) ? 1 : $clog2(WINDOW)
) (
    input  logic              CLK,
    input  logic              RST_POOL,
    input  logic              EN_POOL,
    input  logic              MODE,
    input  logic              FLUSH,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic [IDX_W-1:0]  Out_Index,
    output logic [IDX_W:0]    Out_Count,
    output logic              Out_Valid,
    input  logic              Out_Ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);
    localparam logic [IDX_W:0]   ONE_CNT  = (IDX_W + 1)'(1);

    // Strict comparison, so ties keep the earlier sample.
    function automatic logic better(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b,
                                    input logic              mode_min);
        logic gt;
        logic lt;
        if (SIGNED) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return mode_min ? lt : gt;
    endfunction

    logic [IDX_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] best_q, best_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic              mode_q, mode_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]  out_idx_q, out_idx_d;
    logic [IDX_W:0]    out_cnt_q, out_cnt_d;
    logic              out_vld_q, out_vld_d;

    logic              in_ready;
    logic              accept;
    logic              flush_take;
    logic              first;
    logic              take_new;
    logic              close;
    logic [DATA_W-1:0] cand_data;
    logic [IDX_W-1:0]  cand_idx;

    always_comb begin
        in_ready   = ~RST_POOL & EN_POOL & (~out_vld_q | Out_Ready);
        accept     = In_Valid & in_ready;
        flush_take = FLUSH & in_ready;
        first      = (count_q == '0);
        take_new   = first | better(In_Data, best_q, mode_q);
        cand_data  = take_new ? In_Data : best_q;
        cand_idx   = take_new ? count_q : best_idx_q;
        close      = (accept & (count_q == LAST_IDX)) | (flush_take & (accept | ~first));

        count_d    = count_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        mode_d     = mode_q;
        out_data_d = out_data_q;
        out_idx_d  = out_idx_q;
        out_cnt_d  = out_cnt_q;
        out_vld_d  = out_vld_q;

        if (close) begin
            // Result register is free here: in_ready guarantees it is empty or draining.
            out_data_d = accept ? cand_data : best_q;
            out_idx_d  = accept ? cand_idx : best_idx_q;
            out_cnt_d  = accept ? ({1'b0, count_q} + ONE_CNT) : {1'b0, count_q};
            out_vld_d  = 1'b1;
            count_d    = '0;
        end else begin
            if (accept) begin
                best_d     = cand_data;
                best_idx_d = cand_idx;
                count_d    = count_q + ONE_IDX;
                if (first) begin
                    mode_d = MODE;
                end
            end
            if (out_vld_q & Out_Ready) begin
                out_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_POOL) begin
            count_q    <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            mode_q     <= 1'b0;
            out_data_q <= '0;
            out_idx_q  <= '0;
            out_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            mode_q     <= mode_d;
            out_data_q <= out_data_d;
            out_idx_q  <= out_idx_d;
            out_cnt_q  <= out_cnt_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign In_Ready  = in_ready;
    assign Out_Data  = out_data_q;
    assign Out_Index = out_idx_q;
    assign Out_Count = out_cnt_q;
    assign Out_Valid = out_vld_q;

endmodule

// File: tb/tb_window_pool_comparator.sv
// Bench for window_pool_comparator: an unsigned and a signed instance share one stimulus
// stream; a window-level reference model feeds per-instance scoreboards drained by a monitor.
module tb_window_pool_comparator;

    localparam int DW  = 16;
    localparam int WIN = 4;
    localparam int IW  = 2;

    logic          CLK = 1'b0;
    logic          RST_POOL = 1'b1;
    logic          EN_POOL = 1'b0;
    logic          MODE = 1'b0;
    logic          FLUSH = 1'b0;
    logic [DW-1:0] In_Data = '0;
    logic          In_Valid = 1'b0;
    logic          Out_Ready = 1'b0;

    logic          ir_u, ov_u, ir_s, ov_s;
    logic [DW-1:0] od_u, od_s;
    logic [IW-1:0] oi_u, oi_s;
    logic [IW:0]   oc_u, oc_s;

    window_pool_comparator #(.DATA_W(DW), .WINDOW(WIN), .SIGNED(1'b0), .IDX_W(IW)) dut_u (
        .CLK(CLK), .RST_POOL(RST_POOL), .EN_POOL(EN_POOL), .MODE(MODE), .FLUSH(FLUSH),
        .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(ir_u),
        .Out_Data(od_u), .Out_Index(oi_u), .Out_Count(oc_u), .Out_Valid(ov_u),
        .Out_Ready(Out_Ready));

    window_pool_comparator #(.DATA_W(DW), .WINDOW(WIN), .SIGNED(1'b1), .IDX_W(IW)) dut_s (
        .CLK(CLK), .RST_POOL(RST_POOL), .EN_POOL(EN_POOL), .MODE(MODE), .FLUSH(FLUSH),
        .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(ir_s),
        .Out_Data(od_s), .Out_Index(oi_s), .Out_Count(oc_s), .Out_Valid(ov_s),
        .Out_Ready(Out_Ready));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] d;
        int            idx;
        int            cnt;
        int            cyc;
    } exp_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    exp_t          qu[$];
    exp_t          qs[$];
    logic [DW-1:0] win[$];
    bit            wmode;

    bit            prev_vld[2];
    bit            prev_hs[2];
    logic [DW-1:0] pd[2];
    logic [IW-1:0] pi[2];
    logic [IW:0]   pc[2];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint key(input logic [DW-1:0] v, input bit sgn);
        return sgn ? longint'($signed(v)) : longint'({48'd0, v});
    endfunction

    // Reference: find the extreme value of the window, then its first occurrence.
    task automatic ref_close(input bit sgn, output exp_t e);
        longint ext;
        bit     found;
        ext = key(win[0], sgn);
        foreach (win[i]) begin
            if (wmode ? (key(win[i], sgn) < ext) : (key(win[i], sgn) > ext)) ext = key(win[i], sgn);
        end
        found = 1'b0;
        e.idx = 0;
        foreach (win[i]) begin
            if (!found && key(win[i], sgn) == ext) begin
                e.idx = i;
                found = 1'b1;
            end
        end
        e.d   = win[e.idx];
        e.cnt = win.size();
        e.cyc = cyc;
    endtask

    task automatic step(input bit en, input bit v, input logic [DW-1:0] d, input bit m,
                        input bit f, input bit ordy, input bit rst);
        bit   exp_ir;
        exp_t eu, es;
        @(negedge CLK);
        EN_POOL = en; In_Valid = v; In_Data = d; MODE = m; FLUSH = f;
        Out_Ready = ordy; RST_POOL = rst;
        #1;
        exp_ir = !rst && en && (qu.size() == 0 || ordy);
        chk("in_ready_u", ir_u, exp_ir);
        chk("in_ready_s", ir_s, exp_ir);
        if (rst) begin
            win.delete(); qu.delete(); qs.delete();
        end else begin
            if (v && exp_ir) begin
                if (win.size() == 0) wmode = m;
                win.push_back(d);
            end
            if (win.size() == WIN || (f && exp_ir && win.size() > 0)) begin
                ref_close(1'b0, eu);
                ref_close(1'b1, es);
                qu.push_back(eu);
                qs.push_back(es);
                win.delete();
            end
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input bit m);
        step(1'b1, 1'b1, d, m, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic mon(input int k, input logic vld, input logic [DW-1:0] d,
                       input logic [IW-1:0] ix, input logic [IW:0] cn);
        exp_t  e;
        string t;
        t = (k == 0) ? "u" : "s";
        if (vld) begin
            if (!prev_vld[k] || prev_hs[k]) begin
                if ((k == 0 ? qu.size() : qs.size()) == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_%s data=%0h expected no result (cycle %0d)", t, d, cyc);
                end else begin
                    if (k == 0) e = qu[0]; else e = qs[0];
                    chk({"latency_", t}, cyc, e.cyc + 1);
                    chk({"data_", t}, d, e.d);
                    chk({"index_", t}, ix, e.idx);
                    chk({"count_", t}, cn, e.cnt);
                end
            end else begin
                chk({"hold_", t}, {d, ix, cn}, {pd[k], pi[k], pc[k]});
            end
            if (Out_Ready) begin
                if (k == 0 && qu.size() > 0) void'(qu.pop_front());
                if (k == 1 && qs.size() > 0) void'(qs.pop_front());
            end
        end
        prev_vld[k] = vld;
        prev_hs[k]  = vld && Out_Ready;
        pd[k] = d; pi[k] = ix; pc[k] = cn;
    endtask

    always begin
        @(negedge CLK);
        #2;
        if (RST_POOL) begin
            prev_vld[0] = 1'b0; prev_vld[1] = 1'b0;
            prev_hs[0]  = 1'b0; prev_hs[1]  = 1'b0;
        end else begin
            mon(0, ov_u, od_u, oi_u, oc_u);
            mon(1, ov_s, od_s, oi_s, oc_s);
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] r;
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_valid", {ov_u, ov_s}, 0);
        chk("rst_data", {od_u, od_s}, 0);
        chk("rst_index_count", {oi_u, oc_u, oi_s, oc_s}, 0);

        // Basic max window with a tie
        send(16'd3, 0); send(16'd9, 0); send(16'd9, 0); send(16'd2, 0);
        idle(3);

        // Signedness: min over mixed-sign values
        send(16'h0005, 1); send(16'hFFFE, 1); send(16'h7FFF, 1); send(16'h8000, 1);
        idle(2);

        // Back-pressure: result held, intake blocked, then resumes
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, DW'(i), 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 16'd8, 0, 1'b0, 1'b0, 1'b0);
        send(16'd8, 0); send(16'd7, 0); send(16'd6, 0); send(16'd5, 0);
        idle(2);

        // Flush after two samples, flush while idle, flush with lone sample, flush on completion
        send(16'd4, 0); send(16'd10, 0);
        step(1'b1, 1'b0, '0, 0, 1'b1, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b0, '0, 0, 1'b1, 1'b1, 1'b0);
        idle(2);
        step(1'b1, 1'b1, 16'd77, 1, 1'b1, 1'b1, 1'b0);
        idle(1);
        send(16'd5, 1); send(16'd2, 1); send(16'd2, 1);
        step(1'b1, 1'b1, 16'd9, 1, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Reset mid-window discards partial state
        send(16'd50, 0); send(16'd60, 0);
        step(1'b1, 1'b0, '0, 0, 1'b0, 1'b1, 1'b1);
        send(16'd1, 0); send(16'd2, 0); send(16'd3, 0); send(16'd4, 0);
        idle(2);

        // Enable stall with MODE change mid-window
        send(16'd7, 0); send(16'd3, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'd99, 1, 1'b0, 1'b1, 1'b0);
        send(16'd9, 1); send(16'd1, 1);
        idle(2);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0: r = DW'($urandom_range(0, 3));
                1: case ($urandom_range(0, 3))
                       0: r = 16'h8000;
                       1: r = 16'h7FFF;
                       2: r = 16'hFFFF;
                       default: r = 16'h0000;
                   endcase
                default: r = DW'($urandom);
            endcase
            step($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, r, 1'($urandom),
                 $urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) == 0);
        end

        step(1'b1, 1'b0, '0, 0, 1'b1, 1'b1, 1'b0);
        idle(4);
        chk("leftover_u", qu.size(), 0);
        chk("leftover_s", qs.size(), 0);
        chk("final_valid", {ov_u, ov_s}, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
